// File: rtl/ula.sv
// ula: 32-bit registered arithmetic/logic unit for the processor datapath.
// One 3-bit-coded operation per cycle; result, zero flag and signed-overflow
// flag are registered on the rising edge of clock (latency 1, throughput 1).
// Optional feature macro: ULA_SHIFT_EN -- when defined, code 101 performs a
// logical left shift by entrada2[4:0]; when undefined no shifter is built and
// code 101 produces a zero result.
//
// Interface timing: there is no handshake. Inputs are sampled at every rising
// edge and are always accepted; outputs are valid from just after that edge
// until the next one. Reset is asynchronous and active-high.
module ula (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] entrada1,
  input  logic [31:0] entrada2,
  input  logic [2:0]  ALUControl,
  output logic        zero,
  output logic [31:0] resultado,
  output logic        overflow
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        less_signed;

  logic [31:0] resultado_d, resultado_q;
  logic        zero_d, zero_q;
  logic        overflow_d, overflow_q;

  // Shared adder/subtractor outputs and their two's-complement overflow terms.
  always_comb begin
    sum         = entrada1 + entrada2;
    diff        = entrada1 - entrada2;
    // ADD overflows when both operands share a sign the result does not.
    add_ovf     = (entrada1[31] == entrada2[31]) && (sum[31] != entrada1[31]);
    // SUB overflows when operand signs differ and the result flips A's sign.
    sub_ovf     = (entrada1[31] != entrada2[31]) && (diff[31] != entrada1[31]);
    // Exact signed compare; deliberately not derived from diff's sign bit,
    // which would be wrong whenever the subtraction overflows.
    less_signed = $signed(entrada1) < $signed(entrada2);
  end

  // Next-state selection: operation result, zero flag from the same value,
  // and overflow only for ADD/SUB.
  always_comb begin
    resultado_d = 32'd0;
    overflow_d  = 1'b0;
    case (ALUControl)
      OP_AND: resultado_d = entrada1 & entrada2;
      OP_OR:  resultado_d = entrada1 | entrada2;
      OP_ADD: begin
        resultado_d = sum;
        overflow_d  = add_ovf;
      end
      OP_XOR: resultado_d = entrada1 ^ entrada2;
      OP_NOR: resultado_d = ~(entrada1 | entrada2);
      OP_SLL: begin
`ifdef ULA_SHIFT_EN
        resultado_d = entrada1 << entrada2[4:0];
`else
        resultado_d = 32'd0;
`endif
      end
      OP_SUB: begin
        resultado_d = diff;
        overflow_d  = sub_ovf;
      end
      OP_SLT: resultado_d = {31'd0, less_signed};
      default: resultado_d = 32'd0;
    endcase
    zero_d = (resultado_d == 32'd0);
  end

  // Output registers; reset clears the result, so zero reads 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resultado_q <= 32'd0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      resultado_q <= resultado_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign resultado = resultado_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ula.sv
// tb_ula: directed self-checking bench for ula.
// Inputs are driven on the falling edge; outputs are sampled 1ns after the
// rising edge. Build with or without ULA_SHIFT_EN.
module tb_ula;

  logic        clock;
  logic        reset;
  logic [31:0] entrada1;
  logic [31:0] entrada2;
  logic [2:0]  ALUControl;
  logic        zero;
  logic [31:0] resultado;
  logic        overflow;

  int errors;
  int checks;

  ula dut (
    .clock      (clock),
    .reset      (reset),
    .entrada1   (entrada1),
    .entrada2   (entrada2),
    .ALUControl (ALUControl),
    .zero       (zero),
    .resultado  (resultado),
    .overflow   (overflow)
  );

  // Clock and reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Driver: present one operation, let one rising edge capture it, then sample.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge clock);
    entrada1   = a;
    entrada2   = b;
    ALUControl = op;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    entrada1   = 32'hDEAD_BEEF;
    entrada2   = 32'h1234_5678;
    ALUControl = 3'b010;
    #2; // before the first rising edge at 5ns
    checks++;
    if (resultado !== 32'd0) begin
      errors++;
      $display("FAIL reset_resultado: got %h required %h", resultado, 32'd0);
    end
    checks++;
    if (zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_zero: got %b required 1", zero);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b required 0", overflow);
    end
    @(negedge clock);
    reset = 1'b0;
    drive_op(32'd3, 32'd1, 3'b011);
    checks++;
    if (resultado !== 32'd2) begin
      errors++;
      $display("FAIL reset_first_op_resultado: got %h required %h", resultado, 32'd2);
    end
    checks++;
    if (zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_op_zero: got %b required 0", zero);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va[8];
    logic [31:0] vb[8];
    logic [2:0]  vop[8];
    logic [31:0] er[8];
    logic        ez[8];
    logic        eo[8];
    va[0]=32'd5;         vb[0]=32'd7;         vop[0]=3'b010; er[0]=32'd12;         ez[0]=0; eo[0]=0;
    va[1]=32'd7;         vb[1]=32'd7;         vop[1]=3'b110; er[1]=32'd0;          ez[1]=1; eo[1]=0;
    va[2]=32'h7FFFFFFF;  vb[2]=32'd1;         vop[2]=3'b010; er[2]=32'h80000000;   ez[2]=0; eo[2]=1;
    va[3]=32'h80000000;  vb[3]=32'h80000000;  vop[3]=3'b010; er[3]=32'd0;          ez[3]=1; eo[3]=1;
    va[4]=32'h80000000;  vb[4]=32'd1;         vop[4]=3'b110; er[4]=32'h7FFFFFFF;   ez[4]=0; eo[4]=1;
    va[5]=32'd3;         vb[5]=32'd5;         vop[5]=3'b110; er[5]=32'hFFFFFFFE;   ez[5]=0; eo[5]=0;
    va[6]=32'hFFFFFFFF;  vb[6]=32'd1;         vop[6]=3'b010; er[6]=32'd0;          ez[6]=1; eo[6]=0;
    va[7]=32'h7FFFFFFF;  vb[7]=32'hFFFFFFFF;  vop[7]=3'b110; er[7]=32'h80000000;   ez[7]=0; eo[7]=1;
    for (int i = 0; i < 8; i++) begin
      drive_op(va[i], vb[i], vop[i]);
      checks++;
      if (resultado !== er[i]) begin
        errors++;
        $display("FAIL arith_resultado[%0d]: got %h required %h", i, resultado, er[i]);
      end
      checks++;
      if (zero !== ez[i]) begin
        errors++;
        $display("FAIL arith_zero[%0d]: got %b required %b", i, zero, ez[i]);
      end
      checks++;
      if (overflow !== eo[i]) begin
        errors++;
        $display("FAIL arith_overflow[%0d]: got %b required %b", i, overflow, eo[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0]  vop[4];
    logic [31:0] er[4];
    vop[0]=3'b000; er[0]=32'h00F000F0;
    vop[1]=3'b001; er[1]=32'hFFF0FFF0;
    vop[2]=3'b100; er[2]=32'h000F000F;
    vop[3]=3'b011; er[3]=32'hFF00FF00;
    for (int i = 0; i < 4; i++) begin
      drive_op(32'hF0F0F0F0, 32'h0FF00FF0, vop[i]);
      checks++;
      if (resultado !== er[i]) begin
        errors++;
        $display("FAIL logic_resultado[%0d]: got %h required %h", i, resultado, er[i]);
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++;
        $display("FAIL logic_overflow[%0d]: got %b required 0", i, overflow);
      end
    end
    drive_op(32'hFFFFFFFF, 32'h00000000, 3'b100);
    checks++;
    if (resultado !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL logic_nor_zero: got %h/%b required 00000000/1", resultado, zero);
    end
  endtask

  task automatic test_slt();
    logic [31:0] va[5];
    logic [31:0] vb[5];
    logic [31:0] er[5];
    va[0]=32'hFFFFFFFF; vb[0]=32'd1;         er[0]=32'd1;
    va[1]=32'd1;        vb[1]=32'hFFFFFFFF;  er[1]=32'd0;
    va[2]=32'h80000000; vb[2]=32'd1;         er[2]=32'd1;
    va[3]=32'h7FFFFFFF; vb[3]=32'h80000000;  er[3]=32'd0;
    va[4]=32'd9;        vb[4]=32'd9;         er[4]=32'd0;
    for (int i = 0; i < 5; i++) begin
      drive_op(va[i], vb[i], 3'b111);
      checks++;
      if (resultado !== er[i]) begin
        errors++;
        $display("FAIL slt_resultado[%0d]: got %h required %h", i, resultado, er[i]);
      end
      checks++;
      if (zero !== (er[i] == 32'd0)) begin
        errors++;
        $display("FAIL slt_zero[%0d]: got %b required %b", i, zero, er[i] == 32'd0);
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++;
        $display("FAIL slt_overflow[%0d]: got %b required 0", i, overflow);
      end
    end
  endtask

  task automatic test_shift();
    logic [31:0] e0;
    logic [31:0] e1;
`ifdef ULA_SHIFT_EN
    e0 = 32'd16;
    e1 = 32'h80000000;
`else
    e0 = 32'd0;
    e1 = 32'd0;
`endif
    drive_op(32'd1, 32'h00000024, 3'b101);
    checks++;
    if (resultado !== e0) begin
      errors++;
      $display("FAIL shift_resultado_0: got %h required %h", resultado, e0);
    end
    checks++;
    if (zero !== (e0 == 32'd0)) begin
      errors++;
      $display("FAIL shift_zero_0: got %b required %b", zero, e0 == 32'd0);
    end
    drive_op(32'h80000001, 32'hFFFFFFFF, 3'b101);
    checks++;
    if (resultado !== e1) begin
      errors++;
      $display("FAIL shift_resultado_1: got %h required %h", resultado, e1);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL shift_overflow_1: got %b required 0", overflow);
    end
  endtask

  task automatic test_latency();
    drive_op(32'd20, 32'd22, 3'b010); // 42
    #2; // mid-cycle input change must not reach the outputs
    entrada1   = 32'h7FFFFFFF;
    entrada2   = 32'd1;
    ALUControl = 3'b010;
    #1;
    checks++;
    if (resultado !== 32'd42 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL latency_hold: got %h/%b required 0000002a/0", resultado, overflow);
    end
    @(posedge clock);
    #1;
    checks++;
    if (resultado !== 32'h80000000 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL latency_update: got %h/%b required 80000000/1", resultado, overflow);
    end
    #1; // between edges
    reset = 1'b1;
    #1;
    checks++;
    if (resultado !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL latency_async_reset: got %h/%b/%b required 00000000/1/0", resultado, zero, overflow);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] va[6];
    logic [31:0] vb[6];
    logic [2:0]  vop[6];
    logic [31:0] expv;
    va[0]=32'd100;       vb[0]=32'd1;   vop[0]=3'b110; exp_q.push_back(32'd99);
    va[1]=32'h0000FFFF;  vb[1]=32'hFF;  vop[1]=3'b000; exp_q.push_back(32'h000000FF);
    va[2]=32'h12340000;  vb[2]=32'h5678;vop[2]=3'b001; exp_q.push_back(32'h12345678);
    va[3]=32'hFFFFFFFE;  vb[3]=32'd2;   vop[3]=3'b010; exp_q.push_back(32'd0);
    va[4]=32'hAAAAAAAA;  vb[4]=32'h55555555; vop[4]=3'b011; exp_q.push_back(32'hFFFFFFFF);
    va[5]=32'hFFFFFFFE;  vb[5]=32'hFFFFFFFF; vop[5]=3'b111; exp_q.push_back(32'd1);
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      entrada1   = va[i];
      entrada2   = vb[i];
      ALUControl = vop[i];
      @(posedge clock);
      #1;
      expv = exp_q.pop_front();
      checks++;
      if (resultado !== expv || zero !== (expv == 32'd0)) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h/%b required %h/%b", i, resultado, zero, expv, expv == 32'd0);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_arith();
    test_logic();
    test_slt();
    test_shift();
    test_latency();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
